// File: rtl/ip_m_axis_s2mm_data_if.sv
// Stream handshake bundle shared by the user write port, the S2MM data stream and the S2MM status stream.
interface ip_m_axis_s2mm_data_if #(
   parameter int unsigned TDATA_WIDTH = 128
);
   logic                       tvalid;
   logic                       tready;
   logic [TDATA_WIDTH-1:0]     tdata;
   logic [TDATA_WIDTH/8-1:0]   tkeep;
   logic                       tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/ip_m_axis_s2mm_data.sv
// S2MM data stage: buffers user beats, emits whole WRITE_BURST_LEN bursts with TLAST,
// and tracks DataMover status to report completions and errors.
module ip_m_axis_s2mm_data #(
   parameter int unsigned WRITE_BURST_LEN      = 8,
   parameter int unsigned C_M_AXIS_TDATA_WIDTH = 128,
   parameter int unsigned FIFO_DEPTH           = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   ip_m_axis_s2mm_data_if.slave           uip_wr,
   ip_m_axis_s2mm_data_if.master          m_axis_s2mm,
   ip_m_axis_s2mm_data_if.slave           s_axis_s2mm_sts,
   output logic                           s2mm_burst_done,
   output logic                           s2mm_err,
   output logic [$clog2(FIFO_DEPTH):0]    s2mm_outstanding,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = AW + 1;
   localparam int unsigned BW   = $clog2(WRITE_BURST_LEN + 1);
   localparam logic [CntW-1:0] FullCnt  = CntW'(FIFO_DEPTH);
   localparam logic [CntW-1:0] BurstCnt = CntW'(WRITE_BURST_LEN);
   localparam logic [BW-1:0]   LastBeat = BW'(WRITE_BURST_LEN - 1);

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   logic [C_M_AXIS_TDATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [BW-1:0]   beat_q, beat_d;
   state_e          state_q, state_d;
   logic            push, pop, strm_valid, strm_last, burst_end;
   logic            sts_ready_q, sts_acc, sts_bad, done_q, err_q;
   logic [CntW-1:0] outst_q, outst_d;

   // ---------------- FIFO ----------------
   assign uip_wr.tready = (count_q != FullCnt);
   assign push = uip_wr.tvalid && (count_q != FullCnt);
   assign pop  = strm_valid && m_axis_s2mm.tready;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= uip_wr.tdata;
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // ---------------- Burst FSM ----------------
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      strm_valid = 1'b0;
      strm_last  = 1'b0;
      burst_end  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q >= BurstCnt) state_d = StStream;
         end
         StStream: begin
            strm_valid = 1'b1;
            strm_last  = (beat_q == LastBeat);
            if (pop) begin
               if (strm_last) begin
                  beat_d    = '0;
                  burst_end = 1'b1;
                  // Stay only if another whole burst remains after this pop
                  if (count_q < BurstCnt + CntW'(1)) state_d = StIdle;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   assign m_axis_s2mm.tvalid = strm_valid;
   assign m_axis_s2mm.tlast  = strm_last;
   assign m_axis_s2mm.tdata  = mem[rd_ptr_q];
   assign m_axis_s2mm.tkeep  = '1;

   // ---------------- Status ----------------
   assign s_axis_s2mm_sts.tready = sts_ready_q;
   assign sts_acc = s_axis_s2mm_sts.tvalid && sts_ready_q;
   assign sts_bad = !s_axis_s2mm_sts.tdata[7] || (|s_axis_s2mm_sts.tdata[6:4]) ||
                    (s_axis_s2mm_sts.tdata[3:0] != 4'hA) || (outst_q == '0);

   always_comb begin
      outst_d = outst_q;
      unique case ({burst_end, sts_acc && (outst_q != '0)})
         2'b10:   outst_d = outst_q + CntW'(1);
         2'b01:   outst_d = outst_q - CntW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sts_ready_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         outst_q     <= '0;
      end else begin
         sts_ready_q <= 1'b1;
         done_q      <= sts_acc;
         err_q       <= err_q | (sts_acc & sts_bad);
         outst_q     <= outst_d;
      end
   end

   assign s2mm_burst_done  = done_q;
   assign s2mm_err         = err_q;
   assign s2mm_outstanding = outst_q;
   assign fifo_count       = count_q;
endmodule

// File: tb/tb_ip_m_axis_s2mm_data.sv
// Bench for ip_m_axis_s2mm_data: queue-based stream model, status table and corner sequences.
module tb_ip_m_axis_s2mm_data;
   localparam int unsigned W  = 128;
   localparam int unsigned BL = 8;
   localparam int unsigned FD = 16;

   logic clk = 1'b0;
   logic rstn;
   logic s2mm_burst_done, s2mm_err;
   logic [$clog2(FD):0] s2mm_outstanding, fifo_count;

   always #5 clk = ~clk;

   ip_m_axis_s2mm_data_if #(.TDATA_WIDTH(W)) uip ();
   ip_m_axis_s2mm_data_if #(.TDATA_WIDTH(W)) mx ();
   ip_m_axis_s2mm_data_if #(.TDATA_WIDTH(8)) sts ();

   ip_m_axis_s2mm_data #(
      .WRITE_BURST_LEN(BL), .C_M_AXIS_TDATA_WIDTH(W), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rstn(rstn),
      .uip_wr(uip), .m_axis_s2mm(mx), .s_axis_s2mm_sts(sts),
      .s2mm_burst_done(s2mm_burst_done), .s2mm_err(s2mm_err),
      .s2mm_outstanding(s2mm_outstanding), .fifo_count(fifo_count)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: queue of accepted beats, output index for TLAST position
   logic [W-1:0] q[$];
   int           out_idx;
   bit           mon_en;
   logic         prev_stall;
   logic [W-1:0] prev_data;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("fifo_count_model", fifo_count, q.size());
         chk("wr_ready_model", uip.tready, q.size() != FD);
         if (q.size() == 0) chk("tvalid_when_empty", mx.tvalid, 1'b0);
         if (prev_stall) chk("tdata_hold", mx.tdata, prev_data);
         if (mx.tvalid) chk("tlast_pos", mx.tlast, (out_idx % BL) == BL - 1);
         if (mx.tvalid && mx.tready) begin
            if (q.size() == 0) chk("beat_from_nothing", 1'b1, 1'b0);
            else chk("tdata_order", mx.tdata, q.pop_front());
            out_idx++;
         end
         if (uip.tvalid && uip.tready) q.push_back(uip.tdata);
         prev_stall = mx.tvalid && !mx.tready;
         prev_data  = mx.tdata;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rstn = 1'b0;
      uip.tvalid = 1'b0;
      sts.tvalid = 1'b0;
      mx.tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sts_tready_in_reset", sts.tready, 1'b0);
      rstn = 1'b1;
      q.delete();
      out_idx = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      tick(1);
   endtask

   task automatic push(input logic [W-1:0] d);
      uip.tvalid = 1'b1;
      uip.tdata = d;
      tick(1);
      uip.tvalid = 1'b0;
   endtask

   task automatic send_sts(input logic [7:0] d);
      sts.tvalid = 1'b1;
      sts.tdata = d;
      tick(1);
      sts.tvalid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((q.size() != 0 || mx.tvalid) && n < budget) begin
         tick(1);
         n++;
      end
      if (n >= budget) chk("drain_timeout", 1'b1, 1'b0);
   endtask

   typedef struct {
      logic [7:0] code;
      logic       exp_err;
   } sts_vec_t;

   sts_vec_t vecs[7];
   int start;
   int pushed;
   int guard;

   initial begin
      vecs[0] = '{8'h8A, 1'b0};
      vecs[1] = '{8'hCA, 1'b1};
      vecs[2] = '{8'hAA, 1'b1};
      vecs[3] = '{8'h9A, 1'b1};
      vecs[4] = '{8'h0A, 1'b1};
      vecs[5] = '{8'h8B, 1'b1};
      vecs[6] = '{8'h83, 1'b1};

      uip.tdata = '0; uip.tkeep = '1; uip.tlast = 1'b0;
      sts.tdata = '0; sts.tkeep = '1; sts.tlast = 1'b1;
      mon_en = 1'b0;
      do_reset();

      chk("rst_tvalid", mx.tvalid, 1'b0);
      chk("rst_tlast", mx.tlast, 1'b0);
      chk("rst_done", s2mm_burst_done, 1'b0);
      chk("rst_err", s2mm_err, 1'b0);
      chk("rst_outstanding", s2mm_outstanding, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_sts_tready", sts.tready, 1'b1);
      chk("rst_wr_ready", uip.tready, 1'b1);
      chk("rst_tkeep", mx.tkeep, {(W/8){1'b1}});

      // Seven beats do not start a burst; the eighth does, two cycles later
      mx.tready = 1'b1;
      for (int i = 0; i < 7; i++) push(W'(i));
      tick(3);
      chk("seven_no_tvalid", mx.tvalid, 1'b0);
      chk("seven_count", fifo_count, 7);
      push(W'(7));
      chk("latency_early", mx.tvalid, 1'b0);
      tick(1);
      chk("latency_first", mx.tvalid, 1'b1);
      chk("first_beat_data", mx.tdata, 0);
      wait_drain(40);
      chk("burst1_beats", out_idx, 8);
      chk("burst1_outstanding", s2mm_outstanding, 1);
      chk("burst1_count", fifo_count, 0);

      send_sts(8'h8A);
      chk("okay_done", s2mm_burst_done, 1'b1);
      chk("okay_outstanding", s2mm_outstanding, 0);
      chk("okay_err", s2mm_err, 1'b0);
      tick(1);
      chk("done_one_cycle", s2mm_burst_done, 1'b0);

      // Fill to full under backpressure, refuse the 17th, then two back-to-back bursts
      mx.tready = 1'b0;
      for (int i = 0; i < 16; i++) push(W'(100 + i));
      chk("full_ready", uip.tready, 1'b0);
      chk("full_count", fifo_count, 16);
      uip.tvalid = 1'b1;
      uip.tdata = W'(16'hDEAD);
      tick(1);
      uip.tvalid = 1'b0;
      chk("refused_count", fifo_count, 16);
      chk("stalled_head", mx.tdata, 100);
      start = out_idx;
      mx.tready = 1'b1;
      tick(16);
      chk("b2b_beats", out_idx - start, 16);
      chk("b2b_idle_after", mx.tvalid, 1'b0);
      chk("b2b_outstanding", s2mm_outstanding, 2);
      send_sts(8'h8A);
      chk("dec_to_1", s2mm_outstanding, 1);
      send_sts(8'h8A);
      chk("dec_to_0", s2mm_outstanding, 0);
      chk("b2b_err", s2mm_err, 1'b0);

      // Random push gaps and random backpressure over four bursts
      start = out_idx;
      pushed = 0;
      guard = 0;
      while ((pushed < 32 || q.size() != 0 || mx.tvalid) && guard < 2000) begin
         uip.tvalid = (pushed < 32) && ($urandom_range(0, 2) != 0);
         uip.tdata = {$urandom, $urandom, $urandom, $urandom};
         mx.tready = $urandom_range(0, 1) == 1;
         if (uip.tvalid && uip.tready) pushed++;
         tick(1);
         guard++;
      end
      uip.tvalid = 1'b0;
      if (guard >= 2000) chk("random_timeout", 1'b1, 1'b0);
      chk("random_beats", out_idx - start, 32);
      chk("random_outstanding", s2mm_outstanding, 4);
      mx.tready = 1'b1;
      for (int i = 0; i < 4; i++) send_sts(8'h8A);
      chk("random_sts_outstanding", s2mm_outstanding, 0);
      chk("random_err", s2mm_err, 1'b0);

      // Status with nothing outstanding
      send_sts(8'h8A);
      chk("orphan_done", s2mm_burst_done, 1'b1);
      chk("orphan_err", s2mm_err, 1'b1);
      chk("orphan_outstanding", s2mm_outstanding, 0);
      tick(3);
      chk("orphan_err_sticky", s2mm_err, 1'b1);

      // Status code table, one burst each from reset
      for (int v = 0; v < 7; v++) begin
         do_reset();
         mx.tready = 1'b1;
         for (int i = 0; i < 8; i++) push(W'(v * 16 + i));
         wait_drain(40);
         chk("tbl_pre_outstanding", s2mm_outstanding, 1);
         send_sts(vecs[v].code);
         chk("tbl_done", s2mm_burst_done, 1'b1);
         chk("tbl_outstanding", s2mm_outstanding, 0);
         chk("tbl_err", s2mm_err, vecs[v].exp_err);
         tick(4);
         chk("tbl_err_sticky", s2mm_err, vecs[v].exp_err);
      end

      // Asynchronous reset in the middle of a burst
      do_reset();
      send_sts(8'h8A);
      mx.tready = 1'b1;
      for (int i = 0; i < 8; i++) push(W'(i));
      wait_drain(40);
      mx.tready = 1'b0;
      for (int i = 0; i < 8; i++) push(W'(50 + i));
      tick(2);
      chk("mid_tvalid_pre", mx.tvalid, 1'b1);
      mx.tready = 1'b1;
      tick(3);
      chk("mid_err_pre", s2mm_err, 1'b1);
      chk("mid_outst_pre", s2mm_outstanding, 1);
      mon_en = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("arst_tvalid", mx.tvalid, 1'b0);
      chk("arst_tlast", mx.tlast, 1'b0);
      chk("arst_count", fifo_count, 0);
      chk("arst_outstanding", s2mm_outstanding, 0);
      chk("arst_err", s2mm_err, 1'b0);
      chk("arst_done", s2mm_burst_done, 1'b0);
      chk("arst_sts_tready", sts.tready, 1'b0);
      chk("arst_wr_ready", uip.tready, 1'b1);
      tick(1);
      rstn = 1'b1;
      q.delete();
      out_idx = 0;
      prev_stall = 1'b0;
      tick(4);
      chk("post_rst_tvalid", mx.tvalid, 1'b0);
      chk("post_rst_count", fifo_count, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
